pack_2n_real_to_cfft: RTL
=========================

// Module: pack_2n_real_to_cfft
// PURPOSE
//  Front-end packer for the 2N-point real FFT path: folds a real stream x[n], 2N=16384 samples, into the N=8192-point complex sequence z[m]=x[2m]+j*x[2m+1].
//  Emits z in the two-column, 4-lane beat format (col1/col2 + 11-bit column index) consumed by the complex FFT core whose outputs later feed recover_2n_FFT.
//  Buffers one column: two input beats form one output beat, with a valid/ready handshake on both sides.
// PARAMETERS
//  IN_WIDTH    24  signed width of each input real sample
//  DATA_WIDTH  27  signed width of each output r/i component (sign-extended from IN_WIDTH; DATA_WIDTH>=IN_WIDTH)
//  N_LOG2      13  log2 of complex points per frame; column index width COL_W=N_LOG2-2=11
// PORTS
//  clk          in   1                  clock
//  rst_n        in   1                  synchronous active-low reset
//  in_valid     in   1                  input beat valid
//  in_ready     out  1                  input beat accepted when in_valid&in_ready
//  in_sof       in   1                  qualifies first beat of a frame
//  in_data      in   [7:0][IN_WIDTH]    8 consecutive real samples; lane 0 is earliest
//  out_valid    out  1                  output beat valid
//  out_ready    in   1                  downstream accepts when out_valid&out_ready
//  x_col1_r/i   out  [3:0][DATA_WIDTH]  even column, 4 complex lanes
//  x_col2_r/i   out  [3:0][DATA_WIDTH]  odd column, 4 complex lanes
//  index_col_1  out  COL_W              column index of col1
//  index_col_2  out  COL_W              column index of col2
//  out_sof      out  1                  first output beat of frame
//  out_eof      out  1                  last output beat of frame (cols 2046/2047)
//  frame_err    out  1                  1-cycle pulse: in_sof arrived mid-frame
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=WAIT_SOF, col_cnt=0, out_valid=0, all data/index/sof/eof=0, frame_err=0, in_ready=0 for that cycle. Reset mid-frame drops all held data.
//  - Packing: input beat for column c, lane l: r=sext(in_data[2l]), i=sext(in_data[2l+1]); complex index m=4c+l.
//  - FSM:
//      WAIT_SOF: in_ready=1; beats without in_sof are discarded; an in_sof beat is latched as col 0 -> HOLD.
//      EVEN: next beat is an even column; latch it -> HOLD.
//      HOLD: next beat completes the pair -> load output regs with col1=held, col2=current, then EVEN, or WAIT_SOF after col 2047.
//  - col_cnt (COL_W bits) increments per accepted beat. It wraps 2047->0 only through WAIT_SOF, so a new in_sof is required each frame.
//  - Output register: single stage, registered. Latency: out_valid rises the cycle after the odd beat is accepted.
//  - Outputs hold stable while out_valid&!out_ready.
//  - in_ready = !(state==HOLD && out_valid && !out_ready). A pair never overwrites an unaccepted output beat.
//  - A simultaneous output-accept and pair-complete in the same cycle reloads with no bubble, giving a sustained 1 output beat per 2 input beats.
//  - in_sof accepted in EVEN/HOLD with col_cnt!=0: frame_err pulses, held half is dropped, the beat restarts as col 0 (-> HOLD). A pending output beat is unaffected.
//  - out_sof = (index pair 0/1); out_eof = (2046/2047), both in natural order.
// CONFIGURATION
//  PACK_BITREV_EN defined:
//    - index_col_1/2 = COL_W-bit bit-reversal of natural column index (2k, 2k+1).
//    - Matches the reversed indices the FFT core expects.
//  PACK_BITREV_EN undefined:
//    - index_col_1/2 are natural 2k, 2k+1.
//    - Data ordering is unchanged either way.
// STRUCTURE
//  - Shared fft_pkg holds:
//    - cplx_t typedef (r,i of DATA_WIDTH)
//    - pack_state_e {WAIT_SOF,EVEN,HOLD}
//    - LANES=4 and COL_W
//    - bitrev function
//  - One sub-module, pack_out_reg: the output register with the valid/ready hold. Everything else stays in the top level.
// TESTING
//  1. Ramp frame x[n]=n, back-to-back, out_ready=1:
//     - beat 0 has col1 r={0,2,4,6}, i={1,3,5,7}; col2 r={8,10,12,14}, index 0/1024 (BITREV) or 0/1 (natural).
//     - 1024 beats, out_eof on last.
//  2. Negative sample -1 at IN_WIDTH=24 -> DATA_WIDTH=27 output 27'h7FFFFFF (sign extension).
//  3. out_ready low 5 cycles mid-frame:
//     - outputs frozen.
//     - in_ready drops only in HOLD with output pending; no sample lost or duplicated versus golden.
//  4. in_sof at col_cnt=37:
//     - frame_err pulses exactly once.
//     - next output beat carries col 0/1 of the new frame with out_sof=1.
//  5. rst_n low 1 cycle at col_cnt=500 -> out_valid=0 next cycle; subsequent beats without in_sof are discarded.
//  6. Random in_valid/out_ready (50%) over 3 frames -> bit-exact match to packed golden; rate never exceeds 1 output per 2 inputs.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the 2N-point real FFT front end.
// LANES and COL_W describe the 4-lane, two-column beat format.
package fft_pkg;
  localparam int CPLX_WIDTH = 27;
  localparam int LANES      = 4;
  localparam int COL_W      = 11;

  typedef struct packed {
    logic signed [CPLX_WIDTH-1:0] r;
    logic signed [CPLX_WIDTH-1:0] i;
  } cplx_t;

  typedef enum logic [1:0] {WAIT_SOF, EVEN, HOLD} pack_state_e;

  // Reverse the bit order of a column index
  function automatic logic [COL_W-1:0] bitrev(input logic [COL_W-1:0] v);
    logic [COL_W-1:0] r;
    for (int b = 0; b < COL_W; b++) r[b] = v[COL_W-1-b];
    return r;
  endfunction
endpackage

// File: rtl/pack_out_reg.sv
// Single-stage output register for the packer. A load captures a full
// column pair; the beat is held unchanged until downstream takes it.
import fft_pkg::*;

module pack_out_reg #(
  parameter int DATA_WIDTH = 27
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    nxt_col1_r,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    nxt_col1_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    nxt_col2_r,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    nxt_col2_i,
  input  logic [COL_W-1:0]                    nxt_idx1,
  input  logic [COL_W-1:0]                    nxt_idx2,
  input  logic                                nxt_sof,
  input  logic                                nxt_eof,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    x_col1_r,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    x_col1_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    x_col2_r,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    x_col2_i,
  output logic [COL_W-1:0]                    index_col_1,
  output logic [COL_W-1:0]                    index_col_2,
  output logic                                out_sof,
  output logic                                out_eof
);

  // Capture on load; valid persists until the beat is accepted. The top
  // never loads while an unaccepted beat is pending, so load always wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      x_col1_r    <= '0;
      x_col1_i    <= '0;
      x_col2_r    <= '0;
      x_col2_i    <= '0;
      index_col_1 <= '0;
      index_col_2 <= '0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
    end else begin
      out_valid <= load | (out_valid & ~out_ready);
      if (load) begin
        x_col1_r    <= nxt_col1_r;
        x_col1_i    <= nxt_col1_i;
        x_col2_r    <= nxt_col2_r;
        x_col2_i    <= nxt_col2_i;
        index_col_1 <= nxt_idx1;
        index_col_2 <= nxt_idx2;
        out_sof     <= nxt_sof;
        out_eof     <= nxt_eof;
      end
    end
  end

endmodule

// File: rtl/pack_2n_real_to_cfft.sv
// Packs a real sample stream into complex pairs z[m]=x[2m]+j*x[2m+1] and
// emits them two columns per beat for the complex FFT core.
// Optional build macro PACK_BITREV_EN: output column indices are
// bit-reversed instead of natural order; data ordering is unchanged.
import fft_pkg::*;

module pack_2n_real_to_cfft #(
  parameter int IN_WIDTH   = 24,
  parameter int DATA_WIDTH = 27,
  parameter int N_LOG2     = 13
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_sof,
  input  logic [7:0][IN_WIDTH-1:0]            in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    x_col1_r,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    x_col1_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    x_col2_r,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    x_col2_i,
  output logic [COL_W-1:0]                    index_col_1,
  output logic [COL_W-1:0]                    index_col_2,
  output logic                                out_sof,
  output logic                                out_eof,
  output logic                                frame_err
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'((1 << (N_LOG2 - 2)) - 1);

  pack_state_e                     state, state_nx;
  logic [COL_W-1:0]                col_cnt, col_nx;
  logic                            acc, latch, load, err_c;
  logic [LANES-1:0][DATA_WIDTH-1:0] cur_r, cur_i, held_r, held_i;
  logic [COL_W-1:0]                idx1_nat, idx2_nat, idx1, idx2;

  // Stall only when the pair would complete onto an unaccepted beat
  assign in_ready = rst_n && !(state == HOLD && out_valid && !out_ready);
  assign acc      = in_valid && in_ready;

  // Even samples feed the real part, odd samples the imaginary part
  always_comb begin
    cur_r = '0;
    cur_i = '0;
    for (int l = 0; l < LANES; l++) begin
      cur_r[l] = DATA_WIDTH'($signed(in_data[2*l]));
      cur_i[l] = DATA_WIDTH'($signed(in_data[2*l+1]));
    end
  end

  // State, column counter, held even column and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WAIT_SOF;
      col_cnt   <= '0;
      held_r    <= '0;
      held_i    <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      col_cnt   <= col_nx;
      frame_err <= err_c;
      if (latch) begin
        held_r <= cur_r;
        held_i <= cur_i;
      end
    end
  end

  // Next state: a mid-frame sof restarts at col 0 and drops the held half
  always_comb begin
    state_nx = state;
    col_nx   = col_cnt;
    latch    = 1'b0;
    load     = 1'b0;
    err_c    = 1'b0;
    if (acc) begin
      case (state)
        WAIT_SOF: begin
          if (in_sof) begin
            latch    = 1'b1;
            col_nx   = COL_W'(1);
            state_nx = HOLD;
          end
        end
        EVEN, HOLD: begin
          if (in_sof && col_cnt != '0) begin
            err_c    = 1'b1;
            latch    = 1'b1;
            col_nx   = COL_W'(1);
            state_nx = HOLD;
          end else if (state == EVEN) begin
            latch    = 1'b1;
            col_nx   = col_cnt + COL_W'(1);
            state_nx = HOLD;
          end else begin
            load = 1'b1;
            if (col_cnt == LAST_COL) begin
              col_nx   = '0;
              state_nx = WAIT_SOF;
            end else begin
              col_nx   = col_cnt + COL_W'(1);
              state_nx = EVEN;
            end
          end
        end
        default: state_nx = WAIT_SOF;
      endcase
    end
  end

  // In HOLD the counter is the odd column that completes the pair
  assign idx2_nat = col_cnt;
  assign idx1_nat = {col_cnt[COL_W-1:1], 1'b0};
`ifdef PACK_BITREV_EN
  assign idx1 = bitrev(idx1_nat);
  assign idx2 = bitrev(idx2_nat);
`else
  assign idx1 = idx1_nat;
  assign idx2 = idx2_nat;
`endif

  pack_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .nxt_col1_r  (held_r),
    .nxt_col1_i  (held_i),
    .nxt_col2_r  (cur_r),
    .nxt_col2_i  (cur_i),
    .nxt_idx1    (idx1),
    .nxt_idx2    (idx2),
    .nxt_sof     (idx1_nat == '0),
    .nxt_eof     (idx2_nat == LAST_COL),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .x_col1_r    (x_col1_r),
    .x_col1_i    (x_col1_i),
    .x_col2_r    (x_col2_r),
    .x_col2_i    (x_col2_i),
    .index_col_1 (index_col_1),
    .index_col_2 (index_col_2),
    .out_sof     (out_sof),
    .out_eof     (out_eof)
  );

endmodule
